// File: rtl/multicycle_step_sequencer_if.sv
// multicycle_step_sequencer_if: frontend issue, LSU step and status signals of the step sequencer
interface multicycle_step_sequencer_if #(
    parameter int SEQ_W  = 5,
    parameter int GPR_W  = 5,
    parameter int STEP_B = 4
);
    localparam int OFF_W = SEQ_W + $clog2(STEP_B);
    logic             issue_valid;
    logic             issue_ready;
    logic [GPR_W-1:0] issue_first_reg;
    logic [SEQ_W-1:0] issue_last;
    logic             issue_is_store;
    logic             flush;
    logic             step_valid;
    logic             step_ready;
    logic [GPR_W-1:0] step_reg;
    logic [OFF_W-1:0] step_offset;
    logic [SEQ_W-1:0] step_idx;
    logic             step_last;
    logic             step_is_store;
    logic             busy;
    modport master (
        output issue_valid, issue_first_reg, issue_last, issue_is_store, flush, step_ready,
        input  issue_ready, step_valid, step_reg, step_offset, step_idx, step_last, step_is_store, busy
    );
    modport slave (
        input  issue_valid, issue_first_reg, issue_last, issue_is_store, flush, step_ready,
        output issue_ready, step_valid, step_reg, step_offset, step_idx, step_last, step_is_store, busy
    );
endinterface

// File: rtl/multicycle_step_sequencer.sv
// multicycle_step_sequencer: expands one load/store-multiple op into per-register LSU steps
// Optional zero-bubble chaining of ops is enabled by defining MC_SEQ_BACK_TO_BACK_EN.
module multicycle_step_sequencer #(
    parameter int SEQ_W  = 5,
    parameter int GPR_W  = 5,
    parameter int STEP_B = 4
) (
    input logic                       clk,
    input logic                       resetb,
    multicycle_step_sequencer_if.slave bus
);
    localparam int OFF_W = SEQ_W + $clog2(STEP_B);
`ifdef MC_SEQ_BACK_TO_BACK_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_STEP = 2'd1} state_t;
    state_t           state_q, state_d;
    logic [SEQ_W-1:0] idx_q, idx_d, last_q, last_d;
    logic [GPR_W-1:0] first_q, first_d;
    logic             store_q, store_d;
    logic             ready, valid, busy;
    logic             hs, done;
    assign hs   = state_q == S_STEP && !bus.flush && bus.step_ready;
    assign done = hs && idx_q == last_q;
    // Op context and step counter; async reset drops any op in flight
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            first_q <= '0;
            last_q  <= '0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            first_q <= first_d;
            last_q  <= last_d;
            store_q <= store_d;
        end
    end
    // Next state and handshake outputs; flush overrides both accept and step progress
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        first_d = first_q;
        last_d  = last_q;
        store_d = store_q;
        ready   = 1'b0;
        valid   = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (bus.issue_valid && !bus.flush) begin
                    state_d = S_STEP;
                    idx_d   = '0;
                    first_d = bus.issue_first_reg;
                    last_d  = bus.issue_last;
                    store_d = bus.issue_is_store;
                end
            end
            S_STEP: begin
                busy  = 1'b1;
                valid = !bus.flush;
                ready = BTB && done;
                if (bus.flush) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (BTB && done && bus.issue_valid) begin
                    idx_d   = '0;
                    first_d = bus.issue_first_reg;
                    last_d  = bus.issue_last;
                    store_d = bus.issue_is_store;
                end else if (done) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (hs) begin
                    idx_d = idx_q + SEQ_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                ready   = 1'bx;
                valid   = 1'bx;
                busy    = 1'bx;
            end
        endcase
    end
    assign bus.issue_ready   = ready;
    assign bus.step_valid    = valid;
    assign bus.busy          = busy;
    assign bus.step_reg      = first_q + GPR_W'(idx_q);
    assign bus.step_offset   = OFF_W'(idx_q) * OFF_W'(STEP_B);
    assign bus.step_idx      = idx_q;
    assign bus.step_last     = idx_q == last_q;
    assign bus.step_is_store = store_q;
endmodule

// File: tb/tb_multicycle_step_sequencer.sv
// tb_multicycle_step_sequencer: table-driven ops with a step scoreboard plus hand-built corner sequences
module tb_multicycle_step_sequencer;
    logic clk = 1'b0;
    logic resetb = 1'b0;
    always #5 clk = ~clk;
    multicycle_step_sequencer_if bus ();
    multicycle_step_sequencer dut (.clk(clk), .resetb(resetb), .bus(bus));

    typedef struct packed {
        logic [4:0] r;
        logic [6:0] off;
        logic [4:0] idx;
        logic       last;
        logic       st;
    } step_t;
    typedef struct {
        logic [4:0] f;
        logic [4:0] l;
        bit         st;
        bit         tog;
        int         hs;
    } vec_t;

    step_t exp_q[$];
    int pass_cnt = 0, total_cnt = 0, hs_cnt = 0, cyc = 0;
    int last_hs_cyc = 0, prev_hs_cyc = 0;
    step_t snap;
    bit stalled = 1'b0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", n, a, e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted step is popped and compared; stalled steps must hold
    always @(negedge clk) begin
        step_t cur;
        cur = '{bus.step_reg, bus.step_offset, bus.step_idx, bus.step_last, bus.step_is_store};
        if (!resetb) stalled = 1'b0;
        else begin
            if (stalled && bus.step_valid) chk("stall_hold", 32'(cur), 32'(snap));
            if (bus.step_valid && bus.step_ready) begin
                hs_cnt++;
                prev_hs_cyc = last_hs_cyc;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) chk("unexpected_step", 32'(cur), 32'hffff_ffff);
                else begin
                    step_t e;
                    e = exp_q.pop_front();
                    chk("step_reg", 32'(cur.r), 32'(e.r));
                    chk("step_offset", 32'(cur.off), 32'(e.off));
                    chk("step_idx", 32'(cur.idx), 32'(e.idx));
                    chk("step_last", 32'(cur.last), 32'(e.last));
                    chk("step_is_store", 32'(cur.st), 32'(e.st));
                end
            end
            stalled = bus.step_valid && !bus.step_ready;
            snap = cur;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] f, input logic [4:0] l, input bit s);
        bus.issue_valid = 1'b1;
        bus.issue_first_reg = f;
        bus.issue_last = l;
        bus.issue_is_store = s;
        for (int c = 0; c < 200; c++) begin
            bit acc;
            @(negedge clk);
            acc = bus.issue_ready && !bus.flush;
            if (acc)
                for (int i = 0; i <= int'(l); i++)
                    exp_q.push_back('{f + 5'(i), 7'(i * 4), 5'(i), i == int'(l), s});
            tick();
            if (acc) begin
                bus.issue_valid = 1'b0;
                return;
            end
        end
        chk("issue_timeout", 32'd0, 32'd1);
        bus.issue_valid = 1'b0;
    endtask

    task automatic drain(input bit tog);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (!bus.busy) begin
                tick();
                bus.step_ready = 1'b1;
                return;
            end
            tick();
            bus.step_ready = tog ? ~bus.step_ready : 1'b1;
        end
        chk("drain_timeout", 32'd0, 32'd1);
        bus.step_ready = 1'b1;
    endtask

    vec_t tbl[5];
    int h0, exp_gap;

    initial begin
        tbl[0] = '{5'd29, 5'd3, 1'b0, 1'b0, 4};
        tbl[1] = '{5'd29, 5'd3, 1'b0, 1'b1, 4};
        tbl[2] = '{5'd7, 5'd0, 1'b1, 1'b0, 1};
        tbl[3] = '{5'd31, 5'd31, 1'b1, 1'b0, 32};
        tbl[4] = '{5'd0, 5'd5, 1'b0, 1'b1, 6};
`ifdef MC_SEQ_BACK_TO_BACK_EN
        exp_gap = 1;
`else
        exp_gap = 2;
`endif
        bus.issue_valid = 1'b0;
        bus.issue_first_reg = '0;
        bus.issue_last = '0;
        bus.issue_is_store = 1'b0;
        bus.flush = 1'b0;
        bus.step_ready = 1'b1;
        #12;
        chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("rst_step_valid", 32'(bus.step_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_idx", 32'(bus.step_idx), 32'd0);
        chk("rst_reg", 32'(bus.step_reg), 32'd0);
        chk("rst_store", 32'(bus.step_is_store), 32'd0);
        tick();
        resetb = 1'b1;
        tick();

        for (int v = 0; v < 5; v++) begin
            h0 = hs_cnt;
            issue(tbl[v].f, tbl[v].l, tbl[v].st);
            drain(tbl[v].tog);
            chk("op_handshakes", 32'(hs_cnt - h0), 32'(tbl[v].hs));
            chk("op_queue_empty", 32'(exp_q.size()), 32'd0);
            chk("op_idle_ready", 32'(bus.issue_ready), 32'd1);
        end

        issue(5'd7, 5'd0, 1'b1);
        @(negedge clk);
        chk("single_valid", 32'(bus.step_valid), 32'd1);
        chk("single_last", 32'(bus.step_last), 32'd1);
        chk("single_store", 32'(bus.step_is_store), 32'd1);
        tick();
        @(negedge clk);
        chk("single_done_valid", 32'(bus.step_valid), 32'd0);
        chk("single_done_ready", 32'(bus.issue_ready), 32'd1);
        tick();

        issue(5'd0, 5'd5, 1'b0);
        tick();
        tick();
        chk("flush_at_idx", 32'(bus.step_idx), 32'd2);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_valid_low", 32'(bus.step_valid), 32'd0);
        tick();
        bus.flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_idx", 32'(bus.step_idx), 32'd0);
        chk("flush_valid", 32'(bus.step_valid), 32'd0);
        tick();
        h0 = hs_cnt;
        issue(5'd10, 5'd1, 1'b1);
        drain(1'b0);
        chk("post_flush_hs", 32'(hs_cnt - h0), 32'd2);

        bus.issue_valid = 1'b1;
        bus.issue_first_reg = 5'd3;
        bus.issue_last = 5'd2;
        bus.flush = 1'b1;
        tick();
        bus.issue_valid = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_valid", 32'(bus.step_valid), 32'd0);
        chk("idle_flush_busy", 32'(bus.busy), 32'd0);
        tick();

        issue(5'd0, 5'd1, 1'b0);
        issue(5'd4, 5'd0, 1'b0);
        drain(1'b0);
        chk("b2b_gap", 32'(last_hs_cyc - prev_hs_cyc), 32'(exp_gap));
        chk("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        issue(5'd3, 5'd4, 1'b0);
        tick();
        chk("pre_rst_idx", 32'(bus.step_idx), 32'd1);
        #2;
        resetb = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.step_valid), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_ready", 32'(bus.issue_ready), 32'd1);
        chk("mid_rst_idx", 32'(bus.step_idx), 32'd0);
        exp_q.delete();
        tick();
        resetb = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(bus.step_valid), 32'd0);
            tick();
        end
        chk("post_rst_ready", 32'(bus.issue_ready), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
